plic_mctx: RTL and testbench

Parametrised multi-context platform-level interrupt controller. It is the successor to the single-hart priority-register stub. It latches external interrupt sources through per-source gateways and arbitrates by priority per context against a threshold. It drives one external-interrupt line per context and implements the claim/complete protocol on the memory-mapped port at base 0x50000000.

---
 rtl/plic_pkg.sv | 31 +++
 rtl/plic_gateway.sv | 37 +++
 rtl/plic_mctx.sv | 146 ++++++++++++++
 tb/tb_plic_mctx.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/plic_pkg.sv
// plic_pkg: PLIC register-map offsets, strides and the reserved source ID.
// Helpers return word-aligned byte offsets within the PLIC region.
package plic_pkg;

  localparam logic [29:0] PRIO_BASE  = 30'h0000000;
  localparam logic [29:0] PEND_OFF   = 30'h0001000;
  localparam logic [29:0] MODE_OFF   = 30'h0001080;
  localparam logic [29:0] EN_BASE    = 30'h0002000;
  localparam logic [29:0] EN_STRIDE  = 30'h0000080;
  localparam logic [29:0] CTX_BASE   = 30'h0200000;
  localparam logic [29:0] CTX_STRIDE = 30'h0001000;
  localparam logic [29:0] CLAIM_OFF  = 30'h0000004;
  localparam int          SRC_RSVD   = 0;

  function automatic logic [29:0] prio_addr(input int i);
    return PRIO_BASE + 30'(4 * i);
  endfunction

  function automatic logic [29:0] en_addr(input int c);
    return EN_BASE + EN_STRIDE * 30'(c);
  endfunction

  function automatic logic [29:0] thr_addr(input int c);
    return CTX_BASE + CTX_STRIDE * 30'(c);
  endfunction

  function automatic logic [29:0] claim_addr(input int c);
    return CTX_BASE + CTX_STRIDE * 30'(c) + CLAIM_OFF;
  endfunction

endpackage

// File: rtl/plic_gateway.sv
// plic_gateway: per-source gateway holding pending/inflight state, with a
// one-deep edge latch so one edge seen while busy is replayed after complete.
module plic_gateway (
  input  logic clk,
  input  logic rst_n,
  input  logic i_src,
  input  logic i_edge,
  input  logic i_claim,
  input  logic i_complete,
  output logic o_pending,
  output logic o_inflight
);

  logic r_pending, r_inflight, r_prev, r_latch;
  logic w_busy, w_trig;

  assign w_busy     = r_pending | r_inflight;
  assign w_trig     = i_edge ? (i_src & ~r_prev) : i_src;
  assign o_pending  = r_pending;
  assign o_inflight = r_inflight;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending  <= 1'b0;
      r_inflight <= 1'b0;
      r_prev     <= 1'b0;
      r_latch    <= 1'b0;
    end else begin
      r_prev     <= i_src;
      r_pending  <= i_claim ? 1'b0 : (r_pending | (~w_busy & (w_trig | r_latch)));
      r_inflight <= i_claim ? 1'b1 : (i_complete ? 1'b0 : r_inflight);
      // latch holds while busy; it is consumed by the pending set above
      r_latch    <= i_edge & w_busy & (r_latch | w_trig);
    end
  end

endmodule

// File: rtl/plic_mctx.sv
// plic_mctx: multi-context PLIC with per-context priority arbitration and claim/complete.
// Define PLIC_EDGE_GATEWAY_EN to add the per-source edge/level mode register.
module plic_mctx
  import plic_pkg::*;
#(
  parameter int N_CTX      = 2,
  parameter int N_INT_SRC  = 32,
  parameter int W_INT_PRIO = 3
) (
  input  logic                  CLK,
  input  logic                  RST_X,
  input  logic [29:0]           w_offset,
  input  logic                  w_we,
  input  logic                  w_re,
  input  logic [31:0]           w_wdata,
  output logic [31:0]           w_rdata,
  input  logic [N_INT_SRC-1:0]  w_irq_src,
  output logic [N_CTX-1:0]      w_eip
);

  localparam int W_ID = $clog2(N_INT_SRC);
  localparam logic [N_INT_SRC-1:0] SRC_MASK = ~(N_INT_SRC'(1) << SRC_RSVD);

  logic [W_INT_PRIO-1:0] r_prio [N_INT_SRC];
  logic [N_INT_SRC-1:0]  r_en [N_CTX];
  logic [W_INT_PRIO-1:0] r_thr [N_CTX];
  logic [W_ID-1:0]       r_best_id [N_CTX];
  logic [W_INT_PRIO-1:0] r_best_prio [N_CTX];
  logic [31:0]           r_rdata;

  logic [29:0]           w_a;
  logic [31:0]           w_rd;
  logic [N_INT_SRC-1:0]  w_src, w_pend, w_inflight, w_mode, w_claim, w_cmp, w_prio_we;
  logic [N_CTX-1:0]      w_en_we, w_thr_we, w_cok;
  logic [W_ID-1:0]       w_id;
  logic                  w_id_ok;
  logic [W_ID-1:0]       w_arb_id [N_CTX];
  logic [W_INT_PRIO-1:0] w_arb_prio [N_CTX];

  assign w_a     = w_offset & ~30'h3;
  assign w_src   = w_irq_src & SRC_MASK;
  assign w_id    = w_wdata[W_ID-1:0];
  assign w_id_ok = (w_wdata != 32'd0) && (w_wdata < 32'(N_INT_SRC));
  assign w_rdata = r_rdata;

`ifdef PLIC_EDGE_GATEWAY_EN
  logic [N_INT_SRC-1:0] r_mode;
  logic                 w_mode_we;
  assign w_mode    = r_mode;
  assign w_mode_we = w_we && (w_a == MODE_OFF);
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) r_mode <= '0;
    else if (w_mode_we) r_mode <= w_wdata[N_INT_SRC-1:0] & SRC_MASK;
  end
`else
  assign w_mode = '0;
`endif

  for (genvar i = 0; i < N_INT_SRC; i++) begin : g_gw
    plic_gateway u_gw (
      .clk        (CLK),
      .rst_n      (RST_X),
      .i_src      (w_src[i]),
      .i_edge     (w_mode[i]),
      .i_claim    (w_claim[i]),
      .i_complete (w_cmp[i]),
      .o_pending  (w_pend[i]),
      .o_inflight (w_inflight[i])
    );
  end

  // a claim is honoured only if the registered winner is still pending
  for (genvar c = 0; c < N_CTX; c++) begin : g_ctx
    assign w_eip[c] = r_best_id[c] != '0;
    assign w_cok[c] = (r_best_id[c] != '0) && (r_best_prio[c] != '0) && w_pend[r_best_id[c]];
  end

  always_comb begin
    for (int c = 0; c < N_CTX; c++) begin
      w_arb_id[c]   = '0;
      w_arb_prio[c] = r_thr[c];
      for (int i = 1; i < N_INT_SRC; i++)
        if (w_pend[i] && r_en[c][i] && (r_prio[i] > w_arb_prio[c])) begin
          w_arb_id[c]   = W_ID'(i);
          w_arb_prio[c] = r_prio[i];
        end
    end
  end

  always_comb begin
    w_rd      = '0;
    w_prio_we = '0;
    w_en_we   = '0;
    w_thr_we  = '0;
    w_claim   = '0;
    w_cmp     = '0;
    if (w_a == PEND_OFF) w_rd = 32'(w_pend);
`ifdef PLIC_EDGE_GATEWAY_EN
    if (w_a == MODE_OFF) w_rd = 32'(r_mode);
`endif
    for (int i = 1; i < N_INT_SRC; i++)
      if (w_a == prio_addr(i)) begin
        w_rd         = 32'(r_prio[i]);
        w_prio_we[i] = w_we;
      end
    for (int c = 0; c < N_CTX; c++) begin
      if (w_a == en_addr(c)) begin
        w_rd       = 32'(r_en[c]);
        w_en_we[c] = w_we;
      end
      if (w_a == thr_addr(c)) begin
        w_rd        = 32'(r_thr[c]);
        w_thr_we[c] = w_we;
      end
      if (w_a == claim_addr(c)) begin
        w_rd = w_cok[c] ? 32'(r_best_id[c]) : 32'd0;
        if (w_re && w_cok[c]) w_claim[r_best_id[c]] = 1'b1;
        if (w_we && w_id_ok && w_inflight[w_id] && r_en[c][w_id]) w_cmp[w_id] = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      r_rdata <= '0;
      for (int i = 0; i < N_INT_SRC; i++) r_prio[i] <= '0;
      for (int c = 0; c < N_CTX; c++) begin
        r_en[c]        <= '0;
        r_thr[c]       <= '0;
        r_best_id[c]   <= '0;
        r_best_prio[c] <= '0;
      end
    end else begin
      if (w_re) r_rdata <= w_rd;
      for (int i = 1; i < N_INT_SRC; i++)
        if (w_prio_we[i]) r_prio[i] <= w_wdata[W_INT_PRIO-1:0];
      for (int c = 0; c < N_CTX; c++) begin
        if (w_en_we[c]) r_en[c] <= w_wdata[N_INT_SRC-1:0] & SRC_MASK;
        if (w_thr_we[c]) r_thr[c] <= w_wdata[W_INT_PRIO-1:0];
        r_best_id[c]   <= w_arb_id[c];
        r_best_prio[c] <= (w_arb_id[c] != '0) ? w_arb_prio[c] : '0;
      end
    end
  end

endmodule

// File: tb/tb_plic_mctx.sv
// tb_plic_mctx: directed self-checking bench; read expectations queued at issue
// and popped when registered read data is valid.
module tb_plic_mctx;

  localparam int N_CTX = 2;
  localparam int N_SRC = 32;
  localparam int W_PRIO = 3;
  localparam logic [29:0] PEND = 30'h1000;
  localparam logic [29:0] MODE = 30'h1080;

  logic              CLK = 1'b0;
  logic              RST_X = 1'b0;
  logic [29:0]       w_offset = '0;
  logic              w_we = 1'b0;
  logic              w_re = 1'b0;
  logic [31:0]       w_wdata = '0;
  logic [31:0]       w_rdata;
  logic [N_SRC-1:0]  w_irq_src = '0;
  logic [N_CTX-1:0]  w_eip;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  plic_mctx #(.N_CTX(N_CTX), .N_INT_SRC(N_SRC), .W_INT_PRIO(W_PRIO)) dut (
    .CLK(CLK), .RST_X(RST_X), .w_offset(w_offset), .w_we(w_we), .w_re(w_re),
    .w_wdata(w_wdata), .w_rdata(w_rdata), .w_irq_src(w_irq_src), .w_eip(w_eip)
  );

  always #5 CLK = ~CLK;

  function automatic logic [29:0] a_prio(input int i); return 30'(4 * i); endfunction
  function automatic logic [29:0] a_en(input int c); return 30'h2000 + 30'(c * 'h80); endfunction
  function automatic logic [29:0] a_thr(input int c); return 30'h200000 + 30'(c * 'h1000); endfunction
  function automatic logic [29:0] a_clm(input int c); return 30'h200004 + 30'(c * 'h1000); endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [29:0] a, input logic [31:0] d);
    w_offset = a; w_wdata = d; w_we = 1'b1;
    tick();
    w_we = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [29:0] a, input logic [31:0] e);
    exp_q.push_back(e);
    w_offset = a; w_re = 1'b1;
    tick();
    w_re = 1'b0;
    chk(tag, w_rdata, exp_q.pop_front());
  endtask

  task automatic eip(input string tag, input logic [1:0] e);
    chk(tag, 32'(w_eip), 32'(e));
  endtask

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    eip("eip_in_reset", 2'b00);
    RST_X = 1'b1;
    tick();
    // reset state
    eip("eip_reset", 2'b00);
    rd("rst_prio5", a_prio(5), 0);
    rd("rst_pend", PEND, 0);
    rd("rst_en0", a_en(0), 0);
    rd("rst_en1", a_en(1), 0);
    rd("rst_thr0", a_thr(0), 0);
    rd("rst_thr1", a_thr(1), 0);
    rd("rst_claim0", a_clm(0), 0);
    rd("rst_mode", MODE, 0);
    // single source, latency, claim, complete with source high
    wr(a_prio(5), 3);
    wr(a_en(0), 32'h20);
    wr(a_thr(0), 1);
    w_irq_src[5] = 1'b1;
    tick();
    eip("src5_rise_n1", 2'b00);
    tick();
    eip("src5_rise_n2", 2'b01);
    rd("pend_src5", PEND, 32'h20);
    rd("claim_src5", a_clm(0), 5);
    eip("eip_hold_after_claim", 2'b01);
    tick();
    eip("eip_drop_after_claim", 2'b00);
    rd("pend_inflight_block", PEND, 0);
    wr(a_clm(0), 5);
    tick();
    eip("repend_n1", 2'b00);
    tick();
    eip("repend_n2", 2'b01);
    rd("pend_repend", PEND, 32'h20);
    // back-to-back claims
    w_irq_src[5] = 1'b0;
    rd("b2b_claim_a", a_clm(0), 5);
    rd("b2b_claim_b", a_clm(0), 0);
    wr(a_clm(0), 5);
    tick(2);
    eip("idle_after_b2b", 2'b00);
    // priority and tie-break
    wr(a_prio(3), 2);
    wr(a_prio(7), 2);
    wr(a_en(0), 32'h88);
    w_irq_src[3] = 1'b1;
    w_irq_src[7] = 1'b1;
    tick(3);
    eip("eip_3_7", 2'b01);
    wr(a_prio(7), 4);
    tick();
    rd("claim_prio_win", a_clm(0), 7);
    wr(a_clm(0), 7);
    wr(a_prio(7), 2);
    tick(2);
    rd("claim_tie_low", a_clm(0), 3);
    w_irq_src[3] = 1'b0;
    w_irq_src[7] = 1'b0;
    tick();
    rd("claim_next_7", a_clm(0), 7);
    wr(a_clm(0), 3);
    wr(a_clm(0), 7);
    tick(2);
    rd("pend_clean", PEND, 0);
    eip("eip_clean", 2'b00);
    // threshold on ctx1 and ignored completes
    wr(a_prio(9), 4);
    wr(a_en(1), 32'h200);
    wr(a_thr(1), 4);
    w_irq_src[9] = 1'b1;
    tick(3);
    eip("thr_equal_blocks", 2'b00);
    rd("pend_src9", PEND, 32'h200);
    wr(a_thr(1), 3);
    tick();
    eip("thr_lowered", 2'b10);
    rd("claim_ctx0_none", a_clm(0), 0);
    rd("claim_ctx1_9", a_clm(1), 9);
    tick();
    eip("ctx1_claimed", 2'b00);
    wr(a_clm(0), 9);
    wr(a_clm(1), 0);
    wr(a_clm(1), 40);
    tick(3);
    eip("bad_complete_ignored", 2'b00);
    rd("pend_still_inflight", PEND, 0);
    wr(a_clm(1), 9);
    tick(2);
    eip("good_complete_repend", 2'b10);
    w_irq_src[9] = 1'b0;
    rd("claim_ctx1_again", a_clm(1), 9);
    wr(a_clm(1), 9);
    tick(2);
    eip("idle_after_ctx1", 2'b00);
    // field widths and hardwired bits
    wr(a_prio(2), 32'hFF);
    rd("prio_trunc", a_prio(2), 7);
    wr(a_prio(0), 7);
    rd("prio0_zero", a_prio(0), 0);
    wr(a_en(1), 32'hFFFF_FFFF);
    rd("en_bit0_zero", a_en(1), 32'hFFFF_FFFE);
    wr(a_en(1), 0);
    wr(a_thr(1), 32'h1D);
    rd("thr_trunc", a_thr(1), 5);
    wr(PEND, 32'hFFFF);
    rd("pend_ro", PEND, 0);
    rd("unmapped", 30'h3000, 0);
    wr(MODE, 32'h40);
`ifdef PLIC_EDGE_GATEWAY_EN
    rd("mode_rw", MODE, 32'h40);
    // edge gateway: three pulses, one replayed after complete
    wr(a_prio(6), 5);
    wr(a_en(0), 32'h40);
    w_irq_src[6] = 1'b1; tick(); w_irq_src[6] = 1'b0; tick(2);
    eip("edge_pend", 2'b01);
    w_irq_src[6] = 1'b1; tick(); w_irq_src[6] = 1'b0; tick();
    rd("edge_claim1", a_clm(0), 6);
    w_irq_src[6] = 1'b1; tick(); w_irq_src[6] = 1'b0; tick();
    eip("edge_wait_complete", 2'b00);
    wr(a_clm(0), 6);
    tick(2);
    eip("edge_replay", 2'b01);
    rd("edge_claim2", a_clm(0), 6);
    wr(a_clm(0), 6);
    tick(3);
    eip("edge_dropped", 2'b00);
    rd("edge_claim3", a_clm(0), 0);
`else
    rd("mode_absent", MODE, 0);
`endif
    // reset while a claim is outstanding
    wr(a_en(0), 32'h20);
    w_irq_src[5] = 1'b1;
    tick(3);
    rd("claim_before_rst", a_clm(0), 5);
    w_irq_src[5] = 1'b0;
    RST_X = 1'b0;
    tick();
    RST_X = 1'b1;
    tick();
    eip("eip_after_rst", 2'b00);
    rd("pend_after_rst", PEND, 0);
    rd("prio5_after_rst", a_prio(5), 0);
    rd("claim_after_rst", a_clm(0), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
